// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Polyphonic voice allocator sitting between the MIDI message decoder and the
// per-voice oscillator/envelope engine. Each accepted note event is resolved
// to a voice index by a sequential scan (one voice per cycle), then committed
// to the voice tables and emitted as a one-cycle voice command.
//
// Ports:
//   reg_clk      in   register/control clock (only clock)
//   reset_reg_n  in   asynchronous active-low reset
//   alloc_mode   in   0 = lowest free voice, 1 = round-robin (latched on accept)
//   ev_valid     in   note event present
//   ev_ready     out  allocator can accept an event (high only in IDLE)
//   ev_on        in   1 = note-on, 0 = note-off
//   ev_note      in   MIDI note number
//   ev_vel       in   MIDI velocity
//   voice_idle   in   per-voice pulse: envelope release finished
//   out_valid    out  one-cycle pulse: voice command valid
//   out_voice    out  target voice index
//   out_note     out  note for the target voice
//   out_vel      out  velocity for the target voice
//   out_gate     out  1 = start/retrigger, 0 = release
//   out_steal    out  1 = an active voice was taken over
//   keys_on      out  per-voice gate (key held)
//   voice_free   out  per-voice silent/available flag
//   active_keys  out  popcount of keys_on
//   dbg_state    out  current FSM state (IDLE=0, SCAN=1, COMMIT=2, EMIT=3)
//
// Handshake: an event transfers on a rising reg_clk edge where ev_valid and
// ev_ready are both high. ev_ready is high exactly while the FSM is in IDLE,
// and does not depend on ev_valid. The producer must hold ev_on/ev_note/
// ev_vel/alloc_mode stable while ev_valid is high and ev_ready is low.
// out_valid has no back-pressure: the consumer must take the command in the
// cycle it is presented.
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = 5,
    parameter int AGE_W   = 8
) (
    input  logic               reg_clk,
    input  logic               reset_reg_n,
    input  logic               alloc_mode,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_on,
    input  logic [6:0]         ev_note,
    input  logic [6:0]         ev_vel,
    input  logic [VOICES-1:0]  voice_idle,
    output logic               out_valid,
    output logic [V_WIDTH-1:0] out_voice,
    output logic [6:0]         out_note,
    output logic [6:0]         out_vel,
    output logic               out_gate,
    output logic               out_steal,
    output logic [VOICES-1:0]  keys_on,
    output logic [VOICES-1:0]  voice_free,
    output logic [V_WIDTH:0]   active_keys,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Latched event
    logic               r_ev_on;
    logic [6:0]         r_ev_note;
    logic [6:0]         r_ev_vel;
    logic               r_mode;

    // Scan bookkeeping
    logic [V_WIDTH-1:0] r_scan_cnt;
    logic               r_match_found;
    logic [V_WIDTH-1:0] r_match_v;
    logic               r_free_found;
    logic [V_WIDTH-1:0] r_free_v;
    logic               r_rel_found;
    logic [V_WIDTH-1:0] r_rel_v;
    logic [AGE_W-1:0]   r_rel_age;
    logic               r_held_found;
    logic [V_WIDTH-1:0] r_held_v;
    logic [AGE_W-1:0]   r_held_age;

    // Voice tables
    logic [VOICES-1:0]  r_keys_on;
    logic [VOICES-1:0]  r_voice_free;
    logic [V_WIDTH:0]   r_active_keys;
    logic [6:0]         r_note_tbl [VOICES];
    logic [AGE_W-1:0]   r_age      [VOICES];
    logic [V_WIDTH-1:0] r_rr_ptr;

    // Output registers
    logic               r_out_valid;
    logic [V_WIDTH-1:0] r_out_voice;
    logic [6:0]         r_out_note;
    logic [6:0]         r_out_vel;
    logic               r_out_gate;
    logic               r_out_steal;

    // Combinational helpers
    logic               w_accept;
    logic [V_WIDTH-1:0] w_visit;
    logic               w_v_key;
    logic               w_v_free;
    logic [AGE_W-1:0]   w_v_age;
    logic [6:0]         w_v_note;
    logic               w_sel_valid;
    logic [V_WIDTH-1:0] w_sel_v;
    logic               w_sel_steal;
    logic               w_commit;
    logic [VOICES-1:0]  w_keys_next;
    logic [VOICES-1:0]  w_free_next;
    logic [V_WIDTH:0]   w_pop;

    assign w_accept = (r_state == S_IDLE) && ev_valid;

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ev_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ev_ready = 1'b1;
                if (ev_valid) begin
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_scan_cnt == V_WIDTH'(VOICES - 1)) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: w_next_state = S_EMIT;
            S_EMIT:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Scan: round-robin starts one past the last assigned voice and relies
    // on V_WIDTH-bit wrap-around (VOICES is a power of two).
    // ---------------------------------------------------------------------
    assign w_visit  = r_mode ? (r_rr_ptr + V_WIDTH'(1) + r_scan_cnt) : r_scan_cnt;
    assign w_v_key  = r_keys_on[w_visit];
    assign w_v_free = r_voice_free[w_visit];
    assign w_v_age  = r_age[w_visit];
    assign w_v_note = r_note_tbl[w_visit];

    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            r_ev_on       <= 1'b0;
            r_ev_note     <= '0;
            r_ev_vel      <= '0;
            r_mode        <= 1'b0;
            r_scan_cnt    <= '0;
            r_match_found <= 1'b0;
            r_match_v     <= '0;
            r_free_found  <= 1'b0;
            r_free_v      <= '0;
            r_rel_found   <= 1'b0;
            r_rel_v       <= '0;
            r_rel_age     <= '0;
            r_held_found  <= 1'b0;
            r_held_v      <= '0;
            r_held_age    <= '0;
        end else if (w_accept) begin
            r_ev_on       <= ev_on;
            r_ev_note     <= ev_note;
            r_ev_vel      <= ev_vel;
            r_mode        <= alloc_mode;
            r_scan_cnt    <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_rel_found   <= 1'b0;
            r_held_found  <= 1'b0;
        end else if (r_state == S_SCAN) begin
            r_scan_cnt <= r_scan_cnt + V_WIDTH'(1);
            if (w_v_key && (w_v_note == r_ev_note) && !r_match_found) begin
                r_match_found <= 1'b1;
                r_match_v     <= w_visit;
            end
            if (!w_v_key && w_v_free && !r_free_found) begin
                r_free_found <= 1'b1;
                r_free_v     <= w_visit;
            end
            // Strict greater-than keeps the first-visited voice on age ties.
            if (!w_v_key && !w_v_free && (!r_rel_found || (w_v_age > r_rel_age))) begin
                r_rel_found <= 1'b1;
                r_rel_v     <= w_visit;
                r_rel_age   <= w_v_age;
            end
            if (w_v_key && (!r_held_found || (w_v_age > r_held_age))) begin
                r_held_found <= 1'b1;
                r_held_v     <= w_visit;
                r_held_age   <= w_v_age;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Commit selection. Every voice is either held, free or released, so a
    // note-on always finds a target once the scan has completed.
    // ---------------------------------------------------------------------
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_v     = '0;
        w_sel_steal = 1'b0;
        if (r_ev_on) begin
            w_sel_valid = 1'b1;
            if (r_match_found) begin
                w_sel_v = r_match_v;
            end else if (r_free_found) begin
                w_sel_v = r_free_v;
            end else if (r_rel_found) begin
                w_sel_v     = r_rel_v;
                w_sel_steal = 1'b1;
            end else begin
                w_sel_v     = r_held_v;
                w_sel_steal = 1'b1;
            end
        end else begin
            // Note-off for a note that is not held is dropped silently.
            w_sel_valid = r_match_found;
            w_sel_v     = r_match_v;
        end
    end

    assign w_commit = (r_state == S_COMMIT) && w_sel_valid;

    // Next-state of the status vectors. A voice_idle pulse only frees a
    // voice whose key is already released; a commit to a voice overrides it.
    always_comb begin
        w_keys_next = r_keys_on;
        w_free_next = r_voice_free | (voice_idle & ~r_keys_on);
        if (w_commit) begin
            w_keys_next[w_sel_v] = r_ev_on;
            if (r_ev_on) begin
                w_free_next[w_sel_v] = 1'b0;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < VOICES; i++) begin
            w_pop = w_pop + (V_WIDTH + 1)'(w_keys_next[i]);
        end
    end

    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            r_keys_on     <= '0;
            r_voice_free  <= '1;
            r_active_keys <= '0;
        end else begin
            r_keys_on     <= w_keys_next;
            r_voice_free  <= w_free_next;
            r_active_keys <= w_pop;
        end
    end

    // Note table, ages and round-robin pointer only change on a note-on.
    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            for (int i = 0; i < VOICES; i++) begin
                r_note_tbl[i] <= '0;
                r_age[i]      <= '0;
            end
            r_rr_ptr <= '0;
        end else if (w_commit && r_ev_on) begin
            r_note_tbl[w_sel_v] <= r_ev_note;
            for (int i = 0; i < VOICES; i++) begin
                if (V_WIDTH'(i) == w_sel_v) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != '1) begin
                    r_age[i] <= r_age[i] + AGE_W'(1);
                end
            end
            r_rr_ptr <= w_sel_v;
        end
    end

    // ---------------------------------------------------------------------
    // Output command: loaded at the end of COMMIT so it is presented during
    // EMIT; held otherwise.
    // ---------------------------------------------------------------------
    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            r_out_valid <= 1'b0;
            r_out_voice <= '0;
            r_out_note  <= '0;
            r_out_vel   <= '0;
            r_out_gate  <= 1'b0;
            r_out_steal <= 1'b0;
        end else begin
            r_out_valid <= w_commit;
            if (w_commit) begin
                r_out_voice <= w_sel_v;
                r_out_note  <= r_ev_note;
                r_out_vel   <= r_ev_vel;
                r_out_gate  <= r_ev_on;
                r_out_steal <= w_sel_steal;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_voice   = r_out_voice;
    assign out_note    = r_out_note;
    assign out_vel     = r_out_vel;
    assign out_gate    = r_out_gate;
    assign out_steal   = r_out_steal;
    assign keys_on     = r_keys_on;
    assign voice_free  = r_voice_free;
    assign active_keys = r_active_keys;
    assign dbg_state   = r_state;

endmodule
